p_r3_dma: RTL and testbench



---
 rtl/p_r3_dma_pkg.sv | 16 +
 rtl/p_r3_dma_ctr.sv | 34 +++
 rtl/p_r3_dma.sv | 119 +++++++++++
 tb/tb_p_r3_dma.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/p_r3_dma_pkg.sv
// p_r3_dma_pkg: shared types and default widths for the register-3 DMA engine.
package p_r3_dma_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int LEN_W_DEF  = 16;

   // Controller states. WAIT is spelled S_WAIT to stay clear of the keyword.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/p_r3_dma_ctr.sv
// p_r3_dma_ctr: destination address incrementer and remaining-byte down-counter.
module p_r3_dma_ctr #(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 16
) (
   input  logic              p_phi2,
   input  logic              h_rst_b,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [LEN_W-1:0]  ld_len,
   output logic [ADDR_W-1:0] addr,
   output logic [LEN_W-1:0]  remaining,
   output logic              last
);

   // Exactly one byte left: the next accepted write finishes the transfer.
   assign last = (remaining == LEN_W'(1));

   // Load on start; after each accepted write advance the address (wrapping) and count down.
   always_ff @(posedge p_phi2 or negedge h_rst_b) begin
      if (!h_rst_b) begin
         addr      <= '0;
         remaining <= '0;
      end else if (load) begin
         addr      <= ld_addr;
         remaining <= ld_len;
      end else if (step) begin
         addr      <= addr + ADDR_W'(1);
         remaining <= remaining - LEN_W'(1);
      end
   end

endmodule

// File: rtl/p_r3_dma.sv
// p_r3_dma: drains the host-to-parasite register-3 FIFO into consecutive parasite memory.
module p_r3_dma
   import p_r3_dma_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              p_phi2,
   input  logic              h_rst_b,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              one_byte_mode,
   input  logic              p_data_available,
   input  logic              p_two_bytes_available,
   input  logic [7:0]        p_data,
   output logic              r3_select,
   output logic              r3_rdnw,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  remaining
);

   state_t state, state_nxt;
   logic   mode_q;
   logic   pair_phase;
   logic   ld, step;
   logic   last;

   p_r3_dma_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_ctr (
      .p_phi2    (p_phi2),
      .h_rst_b   (h_rst_b),
      .load      (ld),
      .step      (step),
      .ld_addr   (cfg_addr),
      .ld_len    (cfg_len),
      .addr      (mem_addr),
      .remaining (remaining),
      .last      (last)
   );

   // Next state plus counter load/step strobes; abort overrides everything.
   always_comb begin
      state_nxt = state;
      ld        = 1'b0;
      step      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               ld        = 1'b1;
               state_nxt = (cfg_len == '0) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            // Two-byte mode waits for a full pair, except for a lone trailing byte.
            if (mode_q ? p_data_available
                       : (p_two_bytes_available || (last && p_data_available)))
               state_nxt = S_READ;
         end
         S_READ:  state_nxt = S_WRITE;
         S_WRITE: begin
            if (mem_ack) begin
               step = 1'b1;
               if (last)
                  state_nxt = S_DONE;
               else if (!mode_q && !pair_phase)
                  state_nxt = S_READ;   // second byte of the pair is already present
               else
                  state_nxt = S_WAIT;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         ld        = 1'b0;
         step      = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge p_phi2 or negedge h_rst_b) begin
      if (!h_rst_b) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Latch the register-3 mode at start and track which half of a pair was just written.
   always_ff @(posedge p_phi2 or negedge h_rst_b) begin
      if (!h_rst_b) begin
         mode_q     <= 1'b0;
         pair_phase <= 1'b0;
      end else if (ld) begin
         mode_q     <= one_byte_mode;
         pair_phase <= 1'b0;
      end else if (step && !mode_q) begin
         pair_phase <= ~pair_phase;
      end
   end

   // Capture the FIFO byte at the end of the read strobe cycle; it is held through WRITE.
   always_ff @(posedge p_phi2 or negedge h_rst_b) begin
      if (!h_rst_b)              mem_wdata <= 8'h00;
      else if (state == S_READ)  mem_wdata <= p_data;
   end

   // Outputs decode straight from the state register, so they are glitch-free.
   assign r3_select = (state == S_READ);
   assign r3_rdnw   = 1'b1;
   assign mem_req   = (state == S_WRITE);
   assign done      = (state == S_DONE);
   assign busy      = (state == S_WAIT) || (state == S_READ) || (state == S_WRITE);

endmodule

// File: tb/tb_p_r3_dma.sv
// tb_p_r3_dma: scoreboard bench for the register-3 DMA engine with a FIFO and memory model.
module tb_p_r3_dma;

   localparam int ADDR_W = 16;
   localparam int LEN_W  = 16;

   logic              p_phi2 = 1'b0;
   logic              h_rst_b = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] cfg_addr = '0;
   logic [LEN_W-1:0]  cfg_len = '0;
   logic              one_byte_mode = 1'b0;
   logic              p_data_available = 1'b0;
   logic              p_two_bytes_available = 1'b0;
   logic [7:0]        p_data = 8'h00;
   logic              mem_ack = 1'b0;
   logic              r3_select, r3_rdnw, mem_req, busy, done;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [LEN_W-1:0]  remaining;

   p_r3_dma #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .p_phi2                (p_phi2),
      .h_rst_b               (h_rst_b),
      .start                 (start),
      .abort                 (abort),
      .cfg_addr              (cfg_addr),
      .cfg_len               (cfg_len),
      .one_byte_mode         (one_byte_mode),
      .p_data_available      (p_data_available),
      .p_two_bytes_available (p_two_bytes_available),
      .p_data                (p_data),
      .r3_select             (r3_select),
      .r3_rdnw               (r3_rdnw),
      .mem_req               (mem_req),
      .mem_ack               (mem_ack),
      .mem_addr              (mem_addr),
      .mem_wdata             (mem_wdata),
      .busy                  (busy),
      .done                  (done),
      .remaining             (remaining)
   );

   always #5 p_phi2 = ~p_phi2;

   int n_chk = 0, n_err = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0, sel_cnt = 0;
   int ack_delay = 0, wait_cnt = 0;
   bit prev_sel = 1'b0;
   logic [7:0]  fifo[$];
   logic [23:0] sb[$];   // {addr, data} of each write expected to be accepted

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(posedge p_phi2) cyc <= cyc + 1;

   // FIFO, memory responder and event counters, all evaluated mid-cycle.
   always @(negedge p_phi2) begin
      if (done)      begin done_cnt++; done_cyc = cyc; end
      if (busy)      busy_cnt++;
      if (r3_select) sel_cnt++;
      // the byte under a read strobe leaves the FIFO once that strobe cycle has ended
      if (prev_sel && fifo.size() > 0) fifo.delete(0);
      prev_sel = r3_select;
      p_data                = (fifo.size() > 0) ? fifo[0] : 8'h00;
      p_data_available      = (fifo.size() >= 1);
      p_two_bytes_available = (fifo.size() >= 2);
      if (mem_req) begin
         if (wait_cnt >= ack_delay) begin
            if (sb.size() == 0) chk("unexp_wr", 32'(mem_addr), 32'hFFFFFFFF);
            else begin
               chk("wr_addr", 32'(mem_addr), 32'(sb[0][23:8]));
               chk("wr_data", 32'(mem_wdata), 32'(sb[0][7:0]));
               sb.delete(0);
            end
            mem_ack  = 1'b1;
            wait_cnt = 0;
         end else begin
            if (sb.size() > 0) begin
               chk("hold_addr", 32'(mem_addr), 32'(sb[0][23:8]));
               chk("hold_data", 32'(mem_wdata), 32'(sb[0][7:0]));
            end
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end
   end

   task automatic load(input logic [15:0] a, input logic [7:0] d);
      fifo.push_back(d);
      sb.push_back({a, d});
   endtask

   // One transfer: k is the number of edges from the start edge to the done cycle.
   task automatic run(input string nm, input logic [15:0] a, input logic [15:0] len,
                      input bit one, input int dly, input int k, input int nsel);
      int d0, s0, b0, s;
      ack_delay = dly;
      d0 = done_cnt; s0 = sel_cnt; b0 = busy_cnt;
      @(posedge p_phi2); #1;
      cfg_addr = a; cfg_len = len; one_byte_mode = one; start = 1'b1;
      @(posedge p_phi2); #1;
      start = 1'b0;
      s = cyc;
      for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge p_phi2);
      #1;
      chk($sformatf("%s_done_seen", nm), 32'(done_cnt != d0), 1);
      chk($sformatf("%s_latency", nm), 32'(done_cyc - s), 32'(k));
      repeat (3) @(negedge p_phi2);
      #1;
      chk($sformatf("%s_done_once", nm), 32'(done_cnt - d0), 1);
      chk($sformatf("%s_remaining", nm), 32'(remaining), 0);
      chk($sformatf("%s_sb_empty", nm), 32'(sb.size()), 0);
      chk($sformatf("%s_sel_pulses", nm), 32'(sel_cnt - s0), 32'(nsel));
      chk($sformatf("%s_busy_low", nm), 32'(busy), 0);
      if (len == 0) chk($sformatf("%s_never_busy", nm), 32'(busy_cnt - b0), 0);
   endtask

   initial begin
      int d0, s0, b0;
      // reset state
      repeat (2) @(negedge p_phi2);
      chk("rst_r3_select", 32'(r3_select), 0);
      chk("rst_r3_rdnw", 32'(r3_rdnw), 1);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_remaining", 32'(remaining), 0);
      @(posedge p_phi2); #1;
      h_rst_b = 1'b1;

      // one-byte mode, three bytes
      load(16'h1000, 8'hA1); load(16'h1001, 8'hB2); load(16'h1002, 8'hC3);
      run("one3", 16'h1000, 16'd3, 1'b1, 0, 9, 3);

      // two-byte mode, two pairs, 5 cycles per pair
      load(16'h2000, 8'h11); load(16'h2001, 8'h22); load(16'h2002, 8'h33); load(16'h2003, 8'h44);
      run("two4", 16'h2000, 16'd4, 1'b0, 0, 10, 4);

      // two-byte mode, odd length: lone third byte, partner remains queued
      load(16'h3000, 8'h55); load(16'h3001, 8'h66); load(16'h3002, 8'h77);
      run("two3", 16'h3000, 16'd3, 1'b0, 0, 8, 3);
      fifo.push_back(8'h88);
      repeat (4) @(negedge p_phi2);
      #1;
      chk("two3_partner_left", 32'(fifo.size()), 1);
      chk("two3_no_extra_sel", 32'(r3_select), 0);
      fifo.delete();

      // address wrap
      load(16'hFFFF, 8'h5A); load(16'h0000, 8'hA5);
      run("wrap", 16'hFFFF, 16'd2, 1'b1, 0, 6, 2);

      // withheld acknowledge: request, address and data hold
      load(16'h4000, 8'hDE); load(16'h4001, 8'hAD);
      run("slow", 16'h4000, 16'd2, 1'b1, 4, 14, 2);

      // zero length: done right after start, no reads
      run("zero", 16'h5000, 16'd0, 1'b1, 0, 0, 0);

      // abort while a write is pending
      ack_delay = 1000;
      fifo.push_back(8'h01); fifo.push_back(8'h02); fifo.push_back(8'h03);
      d0 = done_cnt; s0 = sel_cnt;
      @(posedge p_phi2); #1;
      cfg_addr = 16'h6000; cfg_len = 16'd3; one_byte_mode = 1'b1; start = 1'b1;
      @(posedge p_phi2); #1;
      start = 1'b0;
      for (int i = 0; i < 50 && !mem_req; i++) @(negedge p_phi2);
      chk("abort_req_seen", 32'(mem_req), 1);
      @(posedge p_phi2); #1;
      abort = 1'b1;
      @(posedge p_phi2); #1;
      abort = 1'b0;
      @(negedge p_phi2);
      chk("abort_busy_low", 32'(busy), 0);
      chk("abort_req_low", 32'(mem_req), 0);
      repeat (5) @(negedge p_phi2);
      #1;
      chk("abort_no_done", 32'(done_cnt - d0), 0);
      chk("abort_remaining", 32'(remaining), 3);
      chk("abort_addr_hold", 32'(mem_addr), 32'h6000);
      chk("abort_sel_once", 32'(sel_cnt - s0), 1);
      fifo.delete();
      ack_delay = 0;

      // start and abort together in IDLE: abort wins
      d0 = done_cnt; b0 = busy_cnt;
      @(posedge p_phi2); #1;
      cfg_addr = 16'h7000; cfg_len = 16'd5; start = 1'b1; abort = 1'b1;
      @(posedge p_phi2); #1;
      start = 1'b0; abort = 1'b0;
      repeat (3) @(negedge p_phi2);
      #1;
      chk("sa_no_busy", 32'(busy_cnt - b0), 0);
      chk("sa_no_done", 32'(done_cnt - d0), 0);
      chk("sa_not_loaded", 32'(remaining), 3);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
